traffic_ctrl_param: RTL and testbench
=====================================

TRAFFIC_CTRL_PARAM -- requirements
Module: traffic_ctrl_param

Parameters
REQ-001 The block SHALL have parameter MIN_GREEN, default 8, meaning minimum car-green cycles before a crossing is granted.
REQ-002 The block SHALL have parameter YELLOW_CYCLES, default 3, meaning car-yellow duration in cycles.
REQ-003 The block SHALL have parameter CLEAR_CYCLES, default 2, meaning all-red clearance duration in cycles.
REQ-004 The block SHALL have parameter PED_GREEN_CYCLES, default 6, meaning pedestrian-green duration in cycles.
REQ-005 The block SHALL have parameter PED_YELLOW_CYCLES, default 3, meaning pedestrian-yellow duration in cycles.
REQ-006 The block SHALL have parameter BLINK_CYCLES, default 4, meaning the half-period of the night-mode blink in cycles.
REQ-007 The block SHALL have parameter CNT_W, default 8, meaning timer width; every duration parameter SHALL be >=1 and <2^CNT_W.

Interface
REQ-008 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-009 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-010 button  input  1  pedestrian request, synchronous to clk, level or pulse.
REQ-011 night  input  1  night-mode select, synchronous to clk.
REQ-012 green_c, yellow_c, red_c  output  1 each  car lamps.
REQ-013 green_p, yellow_p, red_p  output  1 each  pedestrian lamps.
REQ-014 ped_wait  output  1  latched pedestrian request pending.

Function
REQ-015 The FSM SHALL have states CAR_G, CAR_Y, CLR1, PED_G, PED_Y, CLR2 and NIGHT; all lamp outputs SHALL be registered Moore decodes of the state.
REQ-016 Lamp decode SHALL be as follows:
- CAR_G: green_c, red_p
- CAR_Y: yellow_c, red_p
- CLR1, CLR2: red_c, red_p
- PED_G: red_c, green_p
- PED_Y: red_c, yellow_p
- NIGHT: yellow_c = blink phase, red_p
REQ-017 In every state, at most one lamp per direction SHALL be lit, and green_c and green_p SHALL never both be 1.
REQ-018 A timer SHALL clear to 0 on every state entry and increment each cycle, saturating at 2^CNT_W-1.
REQ-019 CAR_Y, CLR1, PED_G, PED_Y and CLR2 SHALL each last exactly their parameter count of cycles, then advance in order CAR_Y->CLR1->PED_G->PED_Y->CLR2->CAR_G.
REQ-020 CAR_G SHALL advance to CAR_Y on the edge where the request latch is 1 and timer >= MIN_GREEN-1; without a request, CAR_G SHALL hold indefinitely.
REQ-021 The request latch SHALL be set by button=1 at any edge outside PED_G and PED_Y, SHALL be cleared on entry to PED_G, and SHALL drive ped_wait directly.
REQ-022 A button press in PED_G or PED_Y SHALL be ignored.
REQ-023 A press in CLR2 or later SHALL be served in the next crossing cycle.
REQ-024 night=1 SHALL be acted on only in CAR_G: the FSM SHALL move to NIGHT on the next edge; night has priority over a pending request at the same edge.
REQ-025 In NIGHT, the blink phase SHALL start at 1 on entry and toggle every BLINK_CYCLES cycles.
REQ-026 In NIGHT, button SHALL be ignored and the request latch SHALL be held cleared.
REQ-027 night=0 in NIGHT SHALL move the FSM to CLR2 on the next edge, then CAR_G after CLR_CYCLES.
REQ-028 night asserted during a crossing sequence SHALL take effect only after return to CAR_G.

Reset
REQ-029 While rst_n=0, the state SHALL be CAR_G and the timer and request latch 0; outputs SHALL be green_c=1, red_p=1 and all others 0, including ped_wait.
REQ-030 Asserting rst_n mid-sequence SHALL abort immediately to the reset values without passing through any intermediate lamp combination.
REQ-031 After rst_n deasserts, the first timer increment SHALL occur on the first rising edge.

Verification (default parameters)
REQ-032 Idle: reset, hold button=0 for 50 cycles -> green_c=1, red_p=1 throughout, ped_wait=0.
REQ-033 Request: pulse button 1 cycle at cycle 2 after reset -> ped_wait=1 from cycle 3, green_c lasts 8 cycles total, yellow_c 3, all-red 2, green_p 6 (ped_wait drops on its entry), yellow_p 3, all-red 2, then green_c.
REQ-034 Late request: button at cycle 20 of CAR_G -> CAR_Y on the following edge; a held button through PED_G/PED_Y is ignored, but held into CLR2 it triggers a second crossing after 8 car-green cycles.
REQ-035 Night: night=1 in CAR_G -> yellow_c toggles every 4 cycles with red_p=1; button ignored; night=0 -> 2 cycles all-red then green_c.
REQ-036 Reset mid-PED_G: drop rst_n -> outputs immediately green_c=1, red_p=1, ped_wait=0.
REQ-037 Every cycle in all scenarios, the bench SHALL check the one-lamp-per-direction invariant and that green_c and green_p are not both 1.

Source files
------------

// File: rtl/traffic_ctrl_param.sv
// rtl/traffic_ctrl_param.sv - Parameterised car/pedestrian crossing controller with night blink mode
module traffic_ctrl_param #(
   parameter int MIN_GREEN         = 8,
   parameter int YELLOW_CYCLES     = 3,
   parameter int CLEAR_CYCLES      = 2,
   parameter int PED_GREEN_CYCLES  = 6,
   parameter int PED_YELLOW_CYCLES = 3,
   parameter int BLINK_CYCLES      = 4,
   parameter int CNT_W             = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   input  logic night,
   output logic green_c,
   output logic yellow_c,
   output logic red_c,
   output logic green_p,
   output logic yellow_p,
   output logic red_p,
   output logic ped_wait
);

   localparam logic [2:0] CAR_G = 3'd0;
   localparam logic [2:0] CAR_Y = 3'd1;
   localparam logic [2:0] CLR1  = 3'd2;
   localparam logic [2:0] PED_G = 3'd3;
   localparam logic [2:0] PED_Y = 3'd4;
   localparam logic [2:0] CLR2  = 3'd5;
   localparam logic [2:0] NIGHT = 3'd6;

   // Timer values at which each phase ends (timer counts 0..N-1 inside a phase)
   localparam logic [CNT_W-1:0] MIN_G_LAST  = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] PG_LAST     = CNT_W'(PED_GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] PY_LAST     = CNT_W'(PED_YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMER_MAX   = '1;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] timer_nxt;
   logic             req;
   logic             req_nxt;
   logic             blink;
   logic             blink_nxt;
   logic [CNT_W-1:0] blink_cnt;
   logic [CNT_W-1:0] blink_cnt_nxt;
   logic [5:0]       lamps_nxt;

   // Phase sequencing: night only breaks in from CAR_G and wins over a pending request
   always_comb begin
      state_nxt = state;
      case (state)
         CAR_G: begin
            if (night) begin
               state_nxt = NIGHT;
            end else if (req && (timer >= MIN_G_LAST)) begin
               state_nxt = CAR_Y;
            end
         end
         CAR_Y:   if (timer == YEL_LAST) state_nxt = CLR1;
         CLR1:    if (timer == CLR_LAST) state_nxt = PED_G;
         PED_G:   if (timer == PG_LAST)  state_nxt = PED_Y;
         PED_Y:   if (timer == PY_LAST)  state_nxt = CLR2;
         CLR2:    if (timer == CLR_LAST) state_nxt = CAR_G;
         NIGHT:   if (!night)            state_nxt = CLR2;
         default: state_nxt = CAR_G;
      endcase
   end

   // Phase timer restarts at 0 on every state change and saturates instead of wrapping
   always_comb begin
      if (state_nxt != state) begin
         timer_nxt = '0;
      end else if (timer == TIMER_MAX) begin
         timer_nxt = timer;
      end else begin
         timer_nxt = timer + 1'b1;
      end
   end

   // Request latch: consumed on PED_G entry, forced clear around night mode, deaf while pedestrians cross
   always_comb begin
      req_nxt = req;
      if ((state_nxt == PED_G) && (state != PED_G)) begin
         req_nxt = 1'b0;
      end else if ((state == NIGHT) || (state_nxt == NIGHT)) begin
         req_nxt = 1'b0;
      end else if (button && (state != PED_G) && (state != PED_Y)) begin
         req_nxt = 1'b1;
      end
   end

   // Night blink: lit on entry, toggles after every BLINK_CYCLES cycles spent in NIGHT
   always_comb begin
      blink_nxt     = blink;
      blink_cnt_nxt = blink_cnt;
      if ((state_nxt == NIGHT) && (state != NIGHT)) begin
         blink_nxt     = 1'b1;
         blink_cnt_nxt = '0;
      end else if (state == NIGHT) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nxt = '0;
            blink_nxt     = ~blink;
         end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
         end
      end
   end

   // Lamp decode of the upcoming state, {green_c, yellow_c, red_c, green_p, yellow_p, red_p}
   always_comb begin
      lamps_nxt = 6'b100_001;
      case (state_nxt)
         CAR_G:       lamps_nxt = 6'b100_001;
         CAR_Y:       lamps_nxt = 6'b010_001;
         CLR1, CLR2:  lamps_nxt = 6'b001_001;
         PED_G:       lamps_nxt = 6'b001_100;
         PED_Y:       lamps_nxt = 6'b001_010;
         NIGHT:       lamps_nxt = {1'b0, blink_nxt, 1'b0, 3'b001};
         default:     lamps_nxt = 6'b100_001;
      endcase
   end

   // State, timers, latch and registered lamps; reset lands straight on car-green
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CAR_G;
         timer     <= '0;
         req       <= 1'b0;
         blink     <= 1'b0;
         blink_cnt <= '0;
         {green_c, yellow_c, red_c, green_p, yellow_p, red_p} <= 6'b100_001;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         req       <= req_nxt;
         blink     <= blink_nxt;
         blink_cnt <= blink_cnt_nxt;
         {green_c, yellow_c, red_c, green_p, yellow_p, red_p} <= lamps_nxt;
      end
   end

   assign ped_wait = req;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// tb/tb_traffic_ctrl_param.sv - Scoreboard bench for traffic_ctrl_param against a phase/duration reference model
module tb_traffic_ctrl_param;

   localparam int MIN_GREEN         = 8;
   localparam int YELLOW_CYCLES     = 3;
   localparam int CLEAR_CYCLES      = 2;
   localparam int PED_GREEN_CYCLES  = 6;
   localparam int PED_YELLOW_CYCLES = 3;
   localparam int BLINK_CYCLES      = 4;
   localparam int CNT_W             = 8;

   localparam int P_CAR_G = 0;
   localparam int P_CAR_Y = 1;
   localparam int P_CLR1  = 2;
   localparam int P_PED_G = 3;
   localparam int P_PED_Y = 4;
   localparam int P_CLR2  = 5;
   localparam int P_NIGHT = 6;

   localparam logic [6:0] RESET_OUT = 7'b100_001_0;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic button = 1'b0;
   logic night = 1'b0;
   logic green_c, yellow_c, red_c, green_p, yellow_p, red_p, ped_wait;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] exp_q[$];
   logic [6:0] tl_q[$];
   bit active = 1'b0;
   bit tl_on  = 1'b0;
   int tl_k   = 0;

   int m_phase = P_CAR_G;
   int m_t     = 0;
   bit m_req   = 1'b0;
   int dur [6] = '{0, YELLOW_CYCLES, CLEAR_CYCLES, PED_GREEN_CYCLES, PED_YELLOW_CYCLES, CLEAR_CYCLES};

   traffic_ctrl_param #(
      .MIN_GREEN(MIN_GREEN),
      .YELLOW_CYCLES(YELLOW_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES),
      .PED_GREEN_CYCLES(PED_GREEN_CYCLES),
      .PED_YELLOW_CYCLES(PED_YELLOW_CYCLES),
      .BLINK_CYCLES(BLINK_CYCLES),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .button(button),
      .night(night),
      .green_c(green_c),
      .yellow_c(yellow_c),
      .red_c(red_c),
      .green_p(green_p),
      .yellow_p(yellow_p),
      .red_p(red_p),
      .ped_wait(ped_wait)
   );

   always #5 clk = ~clk;

   // Expected outputs for the phase the model currently sits in
   function automatic logic [6:0] model_out();
      logic [5:0] l;
      case (m_phase)
         P_CAR_G:         l = 6'b100_001;
         P_CAR_Y:         l = 6'b010_001;
         P_CLR1, P_CLR2:  l = 6'b001_001;
         P_PED_G:         l = 6'b001_100;
         P_PED_Y:         l = 6'b001_010;
         default:         l = {1'b0, ((m_t / BLINK_CYCLES) % 2 == 0), 4'b0001};
      endcase
      return {l, m_req};
   endfunction

   // One clock edge of the reference model, given the inputs seen at that edge
   function automatic void model_step(input bit b, input bit n);
      int nxt;
      nxt = m_phase;
      if (m_phase == P_CAR_G) begin
         if (n) nxt = P_NIGHT;
         else if (m_req && (m_t >= MIN_GREEN - 1)) nxt = P_CAR_Y;
      end else if (m_phase == P_NIGHT) begin
         if (!n) nxt = P_CLR2;
      end else if (m_t >= dur[m_phase] - 1) begin
         nxt = (m_phase + 1) % 6;
      end
      if ((nxt == P_PED_G) && (m_phase != P_PED_G)) m_req = 1'b0;
      else if ((nxt == P_NIGHT) || (m_phase == P_NIGHT)) m_req = 1'b0;
      else if (b && (m_phase != P_PED_G) && (m_phase != P_PED_Y)) m_req = 1'b1;
      m_t = (nxt == m_phase) ? m_t + 1 : 0;
      m_phase = nxt;
   endfunction

   // Hand-written timeline for a one-cycle press at cycle 2 after reset
   function automatic logic [6:0] tl_exp(input int k);
      if (k < 8)  return {6'b100_001, (k >= 3)};
      if (k < 11) return 7'b010_001_1;
      if (k < 13) return 7'b001_001_1;
      if (k < 19) return 7'b001_100_0;
      if (k < 22) return 7'b001_010_0;
      if (k < 24) return 7'b001_001_0;
      return 7'b100_001_0;
   endfunction

   task automatic report_fail(input string name, input logic [6:0] act, input logic [6:0] req);
      n_fail++;
      $display("FAIL %s at %0t: actual %b required %b", name, $time, act, req);
   endtask

   // Drive one cycle of inputs, let the DUT take the edge, queue what should follow
   task automatic tick(input bit b, input bit n);
      button = b;
      night  = n;
      @(posedge clk);
      model_step(b, n);
      exp_q.push_back(model_out());
      if (tl_on) begin
         tl_k++;
         tl_q.push_back(tl_exp(tl_k));
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      button = 1'b0;
      night  = 1'b0;
      exp_q.delete();
      tl_q.delete();
      m_phase = P_CAR_G;
      m_t     = 0;
      m_req   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.push_back(model_out());
      tl_k = 0;
      if (tl_on) tl_q.push_back(tl_exp(0));
   endtask

   // Monitor: invariants every cycle, reset values while held, scoreboard pops otherwise
   initial begin
      logic [6:0] act;
      logic [6:0] e;
      forever begin
         @(negedge clk);
         if (active) begin
            act = {green_c, yellow_c, red_c, green_p, yellow_p, red_p, ped_wait};
            n_checks++;
            if (($countones({green_c, yellow_c, red_c}) > 1) || ($countones({green_p, yellow_p, red_p}) > 1))
               report_fail("one_lamp_per_direction", act, 7'b0);
            n_checks++;
            if (green_c && green_p) report_fail("no_dual_green", act, 7'b0);
            if (!rst_n) begin
               n_checks++;
               if (act !== RESET_OUT) report_fail("reset_state", act, RESET_OUT);
            end else begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  report_fail("scoreboard_underflow", act, 7'b0);
               end else begin
                  e = exp_q.pop_front();
                  if (act !== e) report_fail("scoreboard", act, e);
               end
               if (tl_q.size() != 0) begin
                  e = tl_q.pop_front();
                  n_checks++;
                  if (act !== e) report_fail("request_timeline", act, e);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit nt;
      #1;
      active = 1'b1;

      // Idle: no requests for 50 cycles
      do_reset();
      repeat (50) tick(1'b0, 1'b0);

      // Single press at cycle 2, full crossing against a fixed timeline
      tl_on = 1'b1;
      do_reset();
      for (int k = 0; k < 30; k++) tick(k == 2, 1'b0);
      tl_on = 1'b0;

      // Late press, then held through the crossing into CLR2
      do_reset();
      repeat (20) tick(1'b0, 1'b0);
      repeat (18) tick(1'b1, 1'b0);
      repeat (40) tick(1'b0, 1'b0);

      // Night raised during a crossing, presses during night, then back to day
      do_reset();
      for (int k = 0; k < 9; k++) tick(k == 3, 1'b0);
      for (int k = 0; k < 45; k++) tick((k % 7) == 2, 1'b1);
      repeat (20) tick(1'b0, 1'b0);

      // Night and a pending request meeting at the same edge
      do_reset();
      repeat (10) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      repeat (12) tick(1'b0, 1'b1);
      repeat (15) tick(1'b0, 1'b0);

      // Reset dropped asynchronously in the middle of PED_G
      do_reset();
      for (int k = 0; k < 15; k++) tick(k == 2, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({green_c, yellow_c, red_c, green_p, yellow_p, red_p, ped_wait} !== RESET_OUT)
         report_fail("async_reset_mid_ped_g", {green_c, yellow_c, red_c, green_p, yellow_p, red_p, ped_wait}, RESET_OUT);
      do_reset();
      repeat (10) tick(1'b0, 1'b0);

      // Randomised traffic with occasional night toggles and resets
      nt = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) nt = ~nt;
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
            nt = 1'b0;
         end
         tick($urandom_range(0, 7) == 0, nt);
      end

      @(negedge clk);
      #1;
      active = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: actual %0d entries left required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
